decode_stage: RTL
=================

# decode_stage

Pipeline decode register between instruction fetch and the execute-side operand logic. It accepts a fetched instruction and its PC over a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready_o`. It presents the decoded RISC-V RV32I fields, including the 12-bit immediate field consumed by the immediate sign-extender, to the next stage over a second valid/ready handshake.

## Interface
- `XLEN`, 32, data/PC width.
- `clk_i` input 1: the single clock. All state updates on its rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `in_valid_i` input 1: upstream has an instruction.
- `in_ready_o` output 1: the block can accept an instruction.
- `instr_i` input 32: raw instruction word.
- `pc_i` input XLEN: PC of `instr_i`.
- `flush_i` input 1: discard all held instructions (branch/jump redirect).
- `out_valid_o` output 1: decoded instruction present.
- `out_ready_i` input 1: downstream consumes the instruction.
- `pc_o` output XLEN: PC of the presented instruction.
- `opcode_o` output 7: `instr[6:0]`.
- `rd_o` output 5: `instr[11:7]`.
- `funct3_o` output 3: `instr[14:12]`.
- `rs1_o` output 5: `instr[19:15]`.
- `rs2_o` output 5: `instr[24:20]`.
- `funct7_o` output 7: `instr[31:25]`.
- `imm_11_o` output 12: immediate field, selected per instruction format.
- `illegal_o` output 1: the presented instruction has an unsupported opcode.

## Operation
- **Storage:** main entry (M) and skid entry (S). Each entry is {valid, instr, pc}. Outputs are decoded combinationally from M only.
- **States:**
  - EMPTY: M and S both empty.
  - ONE: M valid.
  - TWO: M and S both valid.
- **Handshakes:**
  - Accept = `in_valid_i & in_ready_o`.
  - Consume = `out_valid_o & out_ready_i`.
  - `in_ready_o = !S.valid`, from a register only.
  - `out_valid_o = M.valid`.
- **Transitions** (no flush):
  - EMPTY + accept -> ONE.
  - ONE + accept + consume -> ONE, with new data in M.
  - ONE + accept, no consume -> TWO, with new data in S.
  - ONE + consume, no accept -> EMPTY.
  - TWO + consume -> ONE, with S moved to M.
  - TWO never accepts.
- **Ordering:** instructions leave in acceptance order. No drops or duplicates.
- **Flush:** `flush_i` high forces EMPTY on the next edge. It beats a simultaneous accept, and that input is discarded. A consume in the same cycle still counts downstream.
- **Immediate selection** (`imm_11_o`):
  - I-type (LOAD 0000011, OP_IMM 0010011, JALR 1100111): `instr[31:20]`.
  - S-type (STORE 0100011): {`instr[31:25]`, `instr[11:7]`}.
  - B-type (BRANCH 1100011): {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`}, i.e. imm[12:1]. Downstream appends bit 0.
  - All other opcodes: 0.
- **Legal opcodes:** LUI 0110111, AUIPC 0010111, JAL 1101111, JALR, BRANCH, LOAD, STORE, OP_IMM, OP 0110011.
- **Illegal flag:** `illegal_o = M.valid & !legal(opcode)`.

## Timing
- **Reset:** while `rst_i` is high, both valids clear and M/S instr and pc clear to 0. On the cycle after reset:
  - `out_valid_o` = 0 and `illegal_o` = 0.
  - All field outputs = 0.
  - `in_ready_o` = 1.
- **Inputs during reset:** `rst_i` dominates `flush_i` and all handshakes, so inputs are ignored while it is high. Reset mid-operation loses held instructions.
- **Latency:** an instruction accepted at edge N is presented with `out_valid_o` = 1 in cycle N+1.
- **Throughput:** one instruction per cycle while `out_ready_i` stays high.
- **Backpressure:**
  - On the first cycle `out_ready_i` = 0, one extra instruction lands in S.
  - `in_ready_o` drops the following cycle.
  - It returns to 1 the cycle after a consume in TWO.
- **Output stability:** outputs hold while `out_valid_o` = 1 and `out_ready_i` = 0.

## Structure
- **`rv_pkg`:**
  - Opcode constants (`OPC_LUI` ... `OPC_OP`).
  - `imm_fmt_e` enum {IMM_NONE, IMM_I, IMM_S, IMM_B}.
  - `dec_state_e` enum {EMPTY, ONE, TWO}.
  - `fetch_entry_t` struct {valid, instr, pc}.
- **`decode_fields`:** one combinational sub-module. It takes a 32-bit instr and produces all fields, `imm_11`, and legality. It is instantiated once on M.
- **Top:** `decode_stage` holds the state machine and the M/S registers.

## Test plan
- **Throughput:** back-to-back accepts with `out_ready_i` = 1. Input 0xFFF10093 (addi x1,x2,-1) at pc 0x100 -> next cycle:
  - `opcode_o` = 0010011, `rd_o` = 1, `rs1_o` = 2.
  - `imm_11_o` = 0xFFF, `pc_o` = 0x100.
  - One output per cycle, in order.
- **S-type immediate:** input 0x00512423 (sw x5,8(x2)) -> `imm_11_o` = 0x008, `rs2_o` = 5, `rs1_o` = 2, `funct3_o` = 010.
- **B-type immediate:** input 0xFE000EE3 (beq x0,x0,-4) -> `imm_11_o` = 0xFFE.
- **Illegal opcode:** input 0x0000007F -> `illegal_o` = 1, `imm_11_o` = 0.
- **Backpressure:** send A, B, C with `out_ready_i` held 0 -> A in M, B in S, `in_ready_o` = 0, C not accepted. Release `out_ready_i` -> A, B, C delivered in order, with no loss or duplicate.
- **Flush and reset:**
  - `flush_i` in TWO together with an accept -> next cycle `out_valid_o` = 0, `in_ready_o` = 1, and the flushed-cycle input never appears.
  - `rst_i` pulsed while in TWO -> all outputs 0, `in_ready_o` = 1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, decode-stage
// states and the fetch entry record held in the skid buffer.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_fmt_e;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} dec_state_e;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_fmt = IMM_I;
      OPC_STORE:                      imm_fmt = IMM_S;
      OPC_BRANCH:                     imm_fmt = IMM_B;
      default:                        imm_fmt = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Purely combinational RV32I field extraction, 12-bit immediate selection
// and opcode legality check for one instruction word.
module decode_fields
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [6:0]  funct7_o,
  output logic [11:0] imm_11_o,
  output logic        legal_o
);

  imm_fmt_e fmt;

  assign opcode_o = instr_i[6:0];
  assign rd_o     = instr_i[11:7];
  assign funct3_o = instr_i[14:12];
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign funct7_o = instr_i[31:25];
  assign fmt      = imm_fmt(instr_i[6:0]);

  // B-type yields imm[12:1]; the consumer appends the implicit zero bit.
  always_comb begin
    imm_11_o = 12'h000;
    case (fmt)
      IMM_I:   imm_11_o = instr_i[31:20];
      IMM_S:   imm_11_o = {instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_11_o = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
      default: imm_11_o = 12'h000;
    endcase
  end

  always_comb begin
    case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: legal_o = 1'b1;
      default:                                 legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline register with a two-entry skid buffer (main M, skid S);
// in_ready is registered and the presented fields are decoded from M.
module decode_stage
  import rv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [6:0]      funct7_o,
  output logic [11:0]     imm_11_o,
  output logic            illegal_o
);

  dec_state_e   state_q, state_d;
  fetch_entry_t m_q, m_d, s_q, s_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, consume, legal;
  fetch_entry_t incoming;

  assign accept   = in_valid_i & in_ready_q;
  assign consume  = m_q.valid & out_ready_i;
  assign incoming = '{valid: 1'b1, instr: instr_i, pc: pc_i};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      state_d  = EMPTY;
      m_d.valid = 1'b0;
      s_d.valid = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_d     = incoming;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            m_d = incoming;
          end else if (accept) begin
            s_d     = incoming;
            state_d = TWO;
          end else if (consume) begin
            m_d.valid = 1'b0;
            state_d   = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            m_d       = s_q;
            s_d.valid = 1'b0;
            state_d   = ONE;
          end
        end
        default: begin
          state_d   = EMPTY;
          m_d.valid = 1'b0;
          s_d.valid = 1'b0;
        end
      endcase
    end
    // Ready is a pure flop output: it reflects whether S is free next cycle.
    in_ready_d = !s_d.valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  decode_fields u_decode_fields (
    .instr_i  (m_q.instr),
    .opcode_o (opcode_o),
    .rd_o     (rd_o),
    .funct3_o (funct3_o),
    .rs1_o    (rs1_o),
    .rs2_o    (rs2_o),
    .funct7_o (funct7_o),
    .imm_11_o (imm_11_o),
    .legal_o  (legal)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = m_q.valid;
  assign pc_o        = m_q.pc;
  assign illegal_o   = m_q.valid & !legal;

endmodule
